// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RAM arbiter, its three requesters and the RAM.
// The arbiter uses the slave modport; the requesters/RAM side uses master.
interface ram_arbiter_if;
    logic        LoaderSchreiben;
    logic [31:0] LoaderAdresse;
    logic [31:0] LoaderDaten;
    logic        LoaderFertig;

    logic        InstrLesen;
    logic [31:0] InstrAdresse;
    logic [31:0] Instruktion;
    logic        InstrGeladen;

    logic        DatenLesen;
    logic        DatenSchreiben;
    logic [31:0] DatenAdresse;
    logic [31:0] CpuSchreibDaten;
    logic [31:0] CpuLeseDaten;
    logic        DatenFertig;

    logic        RAMLesenAn;
    logic        RAMSchreibenAn;
    logic [31:0] RAMAdresse;
    logic [31:0] RAMDatenRein;
    logic [31:0] RAMDatenRaus;
    logic        RAMDatenBereit;
    logic        RAMDatenGeschrieben;

    logic        Fehler;
    logic [1:0]  Aktiv;

    modport slave (
        input  LoaderSchreiben, LoaderAdresse, LoaderDaten,
        input  InstrLesen, InstrAdresse,
        input  DatenLesen, DatenSchreiben, DatenAdresse, CpuSchreibDaten,
        input  RAMDatenRaus, RAMDatenBereit, RAMDatenGeschrieben,
        output LoaderFertig, Instruktion, InstrGeladen, CpuLeseDaten, DatenFertig,
        output RAMLesenAn, RAMSchreibenAn, RAMAdresse, RAMDatenRein,
        output Fehler, Aktiv
    );

    modport master (
        output LoaderSchreiben, LoaderAdresse, LoaderDaten,
        output InstrLesen, InstrAdresse,
        output DatenLesen, DatenSchreiben, DatenAdresse, CpuSchreibDaten,
        output RAMDatenRaus, RAMDatenBereit, RAMDatenGeschrieben,
        input  LoaderFertig, Instruktion, InstrGeladen, CpuLeseDaten, DatenFertig,
        input  RAMLesenAn, RAMSchreibenAn, RAMAdresse, RAMDatenRein,
        input  Fehler, Aktiv
    );
endinterface

// File: rtl/ram_arbiter.sv
// Fixed-priority arbiter (loader > data > instruction) for the single-port main RAM,
// with registered strobes, one-cycle completion pulses, local MMIO answers and a timeout.
module ram_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic         Clock,
    input  logic         Reset,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ZUGRIFF  = 2'd1,
        QUITTUNG = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE   = 2'd0;
    localparam logic [1:0] GRANT_LOADER = 2'd1;
    localparam logic [1:0] GRANT_DATA   = 2'd2;
    localparam logic [1:0] GRANT_INSTR  = 2'd3;
    localparam logic [9:0] TIMEOUT_CNT  = 10'(TIMEOUT);

    state_t      r_state, w_state;
    logic [1:0]  r_aktiv, w_aktiv;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_wdata, w_wdata;
    logic        r_rd, w_rd;
    logic        r_wr, w_wr;
    logic [9:0]  r_cnt, w_cnt;
    logic        r_fehler, w_fehler;
    logic        r_lf, w_lf;
    logic        r_ig, w_ig;
    logic        r_df, w_df;
    logic [31:0] r_instr, w_instr;
    logic [31:0] r_cpu, w_cpu;

    logic        w_data_req;
    logic        w_mmio;
    logic        w_done;
    logic        w_tmo;
    logic [31:0] w_rdata;

    assign w_data_req = bus.DatenLesen | bus.DatenSchreiben;
    assign w_mmio     = |bus.DatenAdresse[31:29];
    // Only the completion line matching the strobe direction is honoured.
    assign w_done     = r_wr ? bus.RAMDatenGeschrieben : bus.RAMDatenBereit;
    assign w_tmo      = (r_cnt + 10'd1) == TIMEOUT_CNT;
    assign w_rdata    = w_done ? bus.RAMDatenRaus : 32'hFFFF_FFFF;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_aktiv  <= GRANT_NONE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_cnt    <= '0;
            r_fehler <= 1'b0;
            r_lf     <= 1'b0;
            r_ig     <= 1'b0;
            r_df     <= 1'b0;
            r_instr  <= '0;
            r_cpu    <= '0;
        end else begin
            r_state  <= w_state;
            r_aktiv  <= w_aktiv;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_rd     <= w_rd;
            r_wr     <= w_wr;
            r_cnt    <= w_cnt;
            r_fehler <= w_fehler;
            r_lf     <= w_lf;
            r_ig     <= w_ig;
            r_df     <= w_df;
            r_instr  <= w_instr;
            r_cpu    <= w_cpu;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_aktiv  = r_aktiv;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_rd     = r_rd;
        w_wr     = r_wr;
        w_cnt    = r_cnt;
        w_fehler = r_fehler;
        w_lf     = 1'b0;
        w_ig     = 1'b0;
        w_df     = 1'b0;
        w_instr  = r_instr;
        w_cpu    = r_cpu;

        case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (bus.LoaderSchreiben) begin
                    w_aktiv = GRANT_LOADER;
                    w_addr  = bus.LoaderAdresse;
                    w_wdata = bus.LoaderDaten;
                    w_wr    = 1'b1;
                    w_rd    = 1'b0;
                    w_state = ZUGRIFF;
                end else if (w_data_req) begin
                    if (w_mmio) begin
                        // I/O is answered locally; the top level supplies peripheral read data.
                        w_df    = 1'b1;
                        w_aktiv = GRANT_NONE;
                        if (!bus.DatenSchreiben) w_cpu = '0;
                        w_state = QUITTUNG;
                    end else begin
                        w_aktiv = GRANT_DATA;
                        w_addr  = bus.DatenAdresse;
                        w_wdata = bus.CpuSchreibDaten;
                        w_wr    = bus.DatenSchreiben;
                        w_rd    = ~bus.DatenSchreiben;
                        w_state = ZUGRIFF;
                    end
                end else if (bus.InstrLesen) begin
                    w_aktiv = GRANT_INSTR;
                    w_addr  = bus.InstrAdresse;
                    w_wr    = 1'b0;
                    w_rd    = 1'b1;
                    w_state = ZUGRIFF;
                end
            end

            ZUGRIFF: begin
                if (w_done || w_tmo) begin
                    w_rd    = 1'b0;
                    w_wr    = 1'b0;
                    w_cnt   = '0;
                    w_aktiv = GRANT_NONE;
                    w_state = QUITTUNG;
                    if (!w_done) w_fehler = 1'b1;
                    case (r_aktiv)
                        GRANT_LOADER: w_lf = 1'b1;
                        GRANT_DATA: begin
                            w_df = 1'b1;
                            if (r_rd) w_cpu = w_rdata;
                        end
                        GRANT_INSTR: begin
                            w_ig    = 1'b1;
                            w_instr = w_rdata;
                        end
                        default: ;
                    endcase
                end else begin
                    w_cnt = r_cnt + 10'd1;
                end
            end

            QUITTUNG: begin
                w_aktiv = GRANT_NONE;
                w_state = IDLE;
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign bus.LoaderFertig   = r_lf;
    assign bus.InstrGeladen   = r_ig;
    assign bus.DatenFertig    = r_df;
    assign bus.Instruktion    = r_instr;
    assign bus.CpuLeseDaten   = r_cpu;
    assign bus.RAMLesenAn     = r_rd;
    assign bus.RAMSchreibenAn = r_wr;
    assign bus.RAMAdresse     = r_addr;
    assign bus.RAMDatenRein   = r_wdata;
    assign bus.Fehler         = r_fehler;
    assign bus.Aktiv          = r_aktiv;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: small behavioural RAM with programmable latency,
// per-cycle checks of strobes, grants, pulses and data.
module tb_ram_arbiter;
    logic clk;
    logic rst_n;
    ram_arbiter_if ifc ();

    ram_arbiter #(.TIMEOUT(8)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // RAM model: acks on the ram_lat-th strobe cycle; unwritten words read A5A5A5A<addr>.
    int          ram_lat = 1;
    bit          ram_dead = 1'b0;
    bit          ram_cross = 1'b0;
    int          strb_cnt = 0;
    logic [31:0] mem [16];
    bit          mem_vld [16];
    logic        hit;

    int wr_cyc = 0, rd_cyc = 0, lf_n = 0, df_n = 0, ig_n = 0;

    always @(negedge clk) begin
        wr_cyc = wr_cyc + int'(ifc.RAMSchreibenAn);
        rd_cyc = rd_cyc + int'(ifc.RAMLesenAn);
        lf_n   = lf_n + int'(ifc.LoaderFertig);
        df_n   = df_n + int'(ifc.DatenFertig);
        ig_n   = ig_n + int'(ifc.InstrGeladen);
        if (ifc.RAMLesenAn || ifc.RAMSchreibenAn) begin
            strb_cnt = strb_cnt + 1;
            hit = !ram_dead && (strb_cnt == ram_lat);
            if (ifc.RAMSchreibenAn) begin
                ifc.RAMDatenGeschrieben = hit;
                ifc.RAMDatenBereit      = ram_cross;
                ifc.RAMDatenRaus        = 32'h0BAD_0BAD;
                if (hit) begin
                    mem[ifc.RAMAdresse[3:0]]     = ifc.RAMDatenRein;
                    mem_vld[ifc.RAMAdresse[3:0]] = 1'b1;
                end
            end else begin
                ifc.RAMDatenBereit      = hit;
                ifc.RAMDatenGeschrieben = ram_cross;
                if (hit)
                    ifc.RAMDatenRaus = mem_vld[ifc.RAMAdresse[3:0]] ? mem[ifc.RAMAdresse[3:0]]
                                                                    : {28'hA5A5A5A, ifc.RAMAdresse[3:0]};
                else
                    ifc.RAMDatenRaus = 32'h0BAD_0BAD;
            end
        end else begin
            strb_cnt = 0;
            ifc.RAMDatenBereit      = 1'b0;
            ifc.RAMDatenGeschrieben = 1'b0;
            ifc.RAMDatenRaus        = 32'h0BAD_0BAD;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int s0, s1, s2;

    initial begin
        rst_n = 1'b0;
        ifc.LoaderSchreiben = 1'b1;
        ifc.LoaderAdresse   = 32'd5;
        ifc.LoaderDaten     = 32'hDEAD_BEEF;
        ifc.InstrLesen      = 1'b1;
        ifc.InstrAdresse    = 32'd5;
        ifc.DatenLesen      = 1'b1;
        ifc.DatenSchreiben  = 1'b0;
        ifc.DatenAdresse    = 32'd7;
        ifc.CpuSchreibDaten = 32'h0;

        // Reset with every request asserted
        repeat (3) step();
        chk("rst_rd",    32'(ifc.RAMLesenAn), 32'd0);
        chk("rst_wr",    32'(ifc.RAMSchreibenAn), 32'd0);
        chk("rst_aktiv", 32'(ifc.Aktiv), 32'd0);
        chk("rst_pulse", 32'({ifc.LoaderFertig, ifc.DatenFertig, ifc.InstrGeladen}), 32'd0);
        chk("rst_fehl",  32'(ifc.Fehler), 32'd0);
        chk("rst_instr", ifc.Instruktion, 32'd0);
        chk("rst_cpu",   ifc.CpuLeseDaten, 32'd0);

        // Loader wins, write 5 <= DEADBEEF, RAM acks on third strobe cycle
        ram_lat = 3;
        rst_n = 1'b1;
        s0 = wr_cyc;
        s1 = lf_n;
        step();
        chk("ld_aktiv", 32'(ifc.Aktiv), 32'd1);
        chk("ld_wr",    32'(ifc.RAMSchreibenAn), 32'd1);
        chk("ld_rd",    32'(ifc.RAMLesenAn), 32'd0);
        chk("ld_addr",  ifc.RAMAdresse, 32'd5);
        chk("ld_din",   ifc.RAMDatenRein, 32'hDEAD_BEEF);
        ifc.InstrLesen = 1'b0;
        ifc.DatenLesen = 1'b0;
        step();
        step();
        chk("ld_wait",  32'({ifc.LoaderFertig, ifc.RAMSchreibenAn}), 32'b01);
        step();
        chk("ld_done",  32'({ifc.LoaderFertig, ifc.RAMSchreibenAn}), 32'b10);
        chk("ld_aktv0", 32'(ifc.Aktiv), 32'd0);
        chk("ld_wrcyc", 32'(wr_cyc - s0), 32'd3);
        step();
        chk("ld_pulse1", 32'(ifc.LoaderFertig), 32'd0);
        chk("ld_npulse", 32'(lf_n - s1), 32'd1);
        ifc.LoaderSchreiben = 1'b0;
        step();
        chk("ld_idle", 32'({ifc.RAMLesenAn, ifc.RAMSchreibenAn}), 32'd0);

        // Fetch at 5 returns loader data
        ram_lat = 1;
        ifc.InstrLesen = 1'b1;
        ifc.InstrAdresse = 32'd5;
        step();
        chk("if_rd",    32'(ifc.RAMLesenAn), 32'd1);
        chk("if_aktiv", 32'(ifc.Aktiv), 32'd3);
        step();
        chk("if_done",  32'({ifc.InstrGeladen, ifc.RAMLesenAn}), 32'b10);
        chk("if_data",  ifc.Instruktion, 32'hDEAD_BEEF);
        ifc.InstrLesen = 1'b0;
        step();
        chk("if_pulse1", 32'(ifc.InstrGeladen), 32'd0);
        chk("if_hold",   ifc.Instruktion, 32'hDEAD_BEEF);
        step();

        // Data and fetch on the same edge: data first
        ram_lat = 2;
        ifc.DatenAdresse = 32'd7;
        ifc.InstrAdresse = 32'd9;
        ifc.DatenLesen = 1'b1;
        ifc.InstrLesen = 1'b1;
        step();
        chk("ar_aktiv", 32'(ifc.Aktiv), 32'd2);
        chk("ar_addr",  ifc.RAMAdresse, 32'd7);
        step();
        chk("ar_wait",  32'(ifc.DatenFertig), 32'd0);
        step();
        chk("ar_ddone", 32'(ifc.DatenFertig), 32'd1);
        chk("ar_ddata", ifc.CpuLeseDaten, 32'hA5A5_A5A7);
        ifc.DatenLesen = 1'b0;
        step();
        chk("ar_quit",  32'({ifc.DatenFertig, ifc.RAMLesenAn, ifc.Aktiv}), 32'd0);
        step();
        chk("ar_irdon", 32'(ifc.RAMLesenAn), 32'd1);
        chk("ar_iaktv", 32'(ifc.Aktiv), 32'd3);
        chk("ar_iaddr", ifc.RAMAdresse, 32'd9);
        step();
        step();
        chk("ar_idone", 32'(ifc.InstrGeladen), 32'd1);
        chk("ar_idata", ifc.Instruktion, 32'hA5A5_A5A9);
        ifc.InstrLesen = 1'b0;
        step();
        step();

        // Read+write together is a write; wrong-direction ack is ignored
        ram_cross = 1'b1;
        ifc.DatenLesen = 1'b1;
        ifc.DatenSchreiben = 1'b1;
        ifc.DatenAdresse = 32'd3;
        ifc.CpuSchreibDaten = 32'hCAFE_F00D;
        step();
        chk("dw_strb",  32'({ifc.RAMSchreibenAn, ifc.RAMLesenAn}), 32'b10);
        step();
        chk("dw_wait",  32'({ifc.DatenFertig, ifc.RAMSchreibenAn}), 32'b01);
        step();
        chk("dw_done",  32'(ifc.DatenFertig), 32'd1);
        chk("dw_cpu",   ifc.CpuLeseDaten, 32'hA5A5_A5A7);
        ifc.DatenLesen = 1'b0;
        ifc.DatenSchreiben = 1'b0;
        ram_cross = 1'b0;
        step();
        step();
        ram_lat = 1;
        ifc.InstrLesen = 1'b1;
        ifc.InstrAdresse = 32'd3;
        step();
        step();
        chk("dw_rback", ifc.Instruktion, 32'hCAFE_F00D);
        ifc.InstrLesen = 1'b0;
        step();
        step();

        // MMIO write then read: no RAM traffic
        s0 = wr_cyc + rd_cyc;
        ifc.DatenSchreiben = 1'b1;
        ifc.DatenAdresse = 32'h2000_0010;
        step();
        chk("io_wdone", 32'(ifc.DatenFertig), 32'd1);
        chk("io_wstrb", 32'({ifc.RAMSchreibenAn, ifc.RAMLesenAn, ifc.Aktiv}), 32'd0);
        chk("io_wcpu",  ifc.CpuLeseDaten, 32'hA5A5_A5A7);
        ifc.DatenSchreiben = 1'b0;
        step();
        chk("io_pulse1", 32'(ifc.DatenFertig), 32'd0);
        step();
        ifc.DatenLesen = 1'b1;
        ifc.DatenAdresse = 32'hE000_0000;
        step();
        chk("io_rdone", 32'(ifc.DatenFertig), 32'd1);
        chk("io_rdata", ifc.CpuLeseDaten, 32'd0);
        ifc.DatenLesen = 1'b0;
        step();
        step();
        chk("io_noram", 32'(wr_cyc + rd_cyc - s0), 32'd0);

        // Timeout: dead RAM, TIMEOUT = 8
        ram_dead = 1'b1;
        ifc.DatenLesen = 1'b1;
        ifc.DatenAdresse = 32'd1;
        s0 = rd_cyc;
        step();
        chk("to_strb",  32'(ifc.RAMLesenAn), 32'd1);
        chk("to_fehl0", 32'(ifc.Fehler), 32'd0);
        repeat (7) step();
        chk("to_early", 32'({ifc.DatenFertig, ifc.RAMLesenAn}), 32'b01);
        step();
        chk("to_done",  32'(ifc.DatenFertig), 32'd1);
        chk("to_data",  ifc.CpuLeseDaten, 32'hFFFF_FFFF);
        chk("to_fehl1", 32'(ifc.Fehler), 32'd1);
        chk("to_cyc",   32'(rd_cyc - s0), 32'd8);
        ifc.DatenLesen = 1'b0;
        ram_dead = 1'b0;
        step();
        step();
        ifc.InstrLesen = 1'b1;
        ifc.InstrAdresse = 32'd5;
        step();
        step();
        chk("to_after", 32'(ifc.InstrGeladen), 32'd1);
        chk("to_stick", 32'(ifc.Fehler), 32'd1);
        ifc.InstrLesen = 1'b0;
        step();
        step();

        // Reset in the middle of an access
        ram_dead = 1'b1;
        ifc.LoaderSchreiben = 1'b1;
        ifc.LoaderAdresse = 32'd2;
        step();
        step();
        chk("mr_strb", 32'(ifc.RAMSchreibenAn), 32'd1);
        s2 = lf_n + df_n + ig_n;
        rst_n = 1'b0;
        #1;
        chk("mr_async", 32'({ifc.RAMSchreibenAn, ifc.RAMLesenAn, ifc.Aktiv}), 32'd0);
        chk("mr_fehl",  32'(ifc.Fehler), 32'd0);
        chk("mr_data",  ifc.Instruktion | ifc.CpuLeseDaten, 32'd0);
        ifc.LoaderSchreiben = 1'b0;
        ram_dead = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("mr_nopls", 32'(lf_n + df_n + ig_n - s2), 32'd0);
        chk("mr_idle",  32'({ifc.RAMSchreibenAn, ifc.RAMLesenAn}), 32'd0);
        ifc.InstrLesen = 1'b1;
        ifc.InstrAdresse = 32'd5;
        step();
        chk("mr_grant", 32'(ifc.Aktiv), 32'd3);
        step();
        chk("mr_fetch", ifc.Instruktion, 32'hDEAD_BEEF);
        ifc.InstrLesen = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
